// File: rtl/mdl_unit_if.sv
// mdl_unit_if: request/response bundle for the mdl_unit execute unit.
// master drives in_valid/op/input1/input2/out_ready; slave returns the rest.
interface mdl_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             illegal;

  modport master (
    output in_valid, op, input1, input2, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, op, input1, input2, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/mdl_unit.sv
// mdl_unit: registered execute unit (logic/arith/compare, iterative
// multiply, optional iterative divide when MDL_DIV_EN is defined).
// Ports: clk; rst (sync, active-high); bus (mdl_unit_if.slave) with
// in_valid/in_ready/op/input1/input2 and out_valid/out_ready/result/illegal.
module mdl_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mdl_unit_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CW = SHAMT_W + 1;
  // Final iteration index; the last step also applies signs.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [4:0] OP_AND = 5'd0;
  localparam logic [4:0] OP_OR  = 5'd1;
  localparam logic [4:0] OP_ADD = 5'd2;
  localparam logic [4:0] OP_SUB = 5'd3;
  localparam logic [4:0] OP_LT  = 5'd4;
  localparam logic [4:0] OP_SRL = 5'd5;
  localparam logic [4:0] OP_SLL = 5'd6;
  localparam logic [4:0] OP_SRA = 5'd7;
  localparam logic [4:0] OP_XOR = 5'd8;
  localparam logic [4:0] OP_LTU = 5'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef MDL_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t             r_state, w_state;
  logic [WIDTH-1:0]   r_result, w_result;
  logic               r_illegal, w_illegal;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic [2*WIDTH-1:0] r_acc, w_acc;
  logic [WIDTH-1:0]   r_opb, w_opb;
  logic               r_neg, w_neg;
  logic               r_hi, w_hi;

  logic [WIDTH-1:0]   w_a, w_b;
  logic [SHAMT_W-1:0] w_sh;
  logic               w_take, w_is_mul;
  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_ma, w_mb;
  logic [WIDTH-1:0]   w_alu;
  logic               w_ill;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mstep, w_prod;

  assign w_a      = bus.input1;
  assign w_b      = bus.input2;
  assign w_sh     = bus.input2[SHAMT_W-1:0];
  assign w_take   = bus.in_valid && bus.in_ready;
  assign w_is_mul = (bus.op[4:2] == 3'b100);

  // Multiply: MULHU unsigned A, MULHSU/MULHU unsigned B.
  // Divide: op[0] set means unsigned.
  assign w_sa = w_is_mul ? (~(bus.op[1] & bus.op[0]) & w_a[WIDTH-1])
                         : (~bus.op[0] & w_a[WIDTH-1]);
  assign w_sb = w_is_mul ? (~bus.op[1] & w_b[WIDTH-1])
                         : (~bus.op[0] & w_b[WIDTH-1]);
  assign w_ma = w_sa ? (-w_a) : w_a;
  assign w_mb = w_sb ? (-w_b) : w_b;

  // Shift-add: acc = {partial, multiplier}, shifted right each step.
  assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mstep = {w_msum, r_acc[WIDTH-1:1]};
  assign w_prod  = r_neg ? (-w_mstep) : w_mstep;

`ifdef MDL_DIV_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic               r_rneg, w_rneg;
  logic               w_is_div, w_dz, w_ovf, w_spec, w_ge;
  logic [WIDTH-1:0]   w_sres, w_dif, w_quo, w_rem;
  logic [WIDTH:0]     w_rsh;
  logic [2*WIDTH-1:0] w_dstep;

  assign w_is_div = (bus.op[4:2] == 3'b101);
  assign w_dz     = (w_b == '0);
  assign w_ovf    = ~bus.op[0] & (w_a == MIN_NEG) & (&w_b);
  assign w_spec   = w_dz | w_ovf;
  assign w_sres   = w_dz ? (bus.op[1] ? w_a : '1)
                         : (bus.op[1] ? '0 : w_a);

  // Restoring step: acc = {remainder, dividend bits}.
  assign w_rsh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge    = (w_rsh >= {1'b0, r_opb});
  assign w_dif   = w_rsh[WIDTH-1:0] - r_opb;
  assign w_dstep = w_ge
    ? {w_dif, r_acc[WIDTH-2:0], 1'b1}
    : {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
  assign w_quo = r_neg ? (-w_dstep[WIDTH-1:0])
                       : w_dstep[WIDTH-1:0];
  assign w_rem = r_rneg ? (-w_dstep[2*WIDTH-1:WIDTH])
                        : w_dstep[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    w_alu = '0;
    w_ill = 1'b0;
    unique case (bus.op)
      OP_AND: w_alu = w_a & w_b;
      OP_OR:  w_alu = w_a | w_b;
      OP_ADD: w_alu = w_a + w_b;
      OP_SUB: w_alu = w_a - w_b;
      OP_LT:  w_alu = WIDTH'($signed(w_a) < $signed(w_b));
      OP_SRL: w_alu = w_a >> w_sh;
      OP_SLL: w_alu = w_a << w_sh;
      OP_SRA: w_alu = $unsigned($signed(w_a) >>> w_sh);
      OP_XOR: w_alu = w_a ^ w_b;
      OP_LTU: w_alu = WIDTH'(w_a < w_b);
      default: begin
        w_ill = 1'b1;
        w_alu = w_a + w_b;
      end
    endcase
  end

  always_comb begin
    w_state   = r_state;
    w_result  = r_result;
    w_illegal = r_illegal;
    w_cnt     = r_cnt;
    w_acc     = r_acc;
    w_opb     = r_opb;
    w_neg     = r_neg;
    w_hi      = r_hi;
`ifdef MDL_DIV_EN
    w_rneg    = r_rneg;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_take) begin
          w_illegal = 1'b0;
          w_cnt     = '0;
          unique case (1'b1)
            w_is_mul: begin
              w_state = MUL;
              w_acc   = {{WIDTH{1'b0}}, w_mb};
              w_opb   = w_ma;
              w_neg   = w_sa ^ w_sb;
              w_hi    = |bus.op[1:0];
            end
`ifdef MDL_DIV_EN
            w_is_div && w_spec: begin
              w_state  = DONE;
              w_result = w_sres;
            end
            w_is_div && !w_spec: begin
              w_state = DIV;
              w_acc   = {{WIDTH{1'b0}}, w_ma};
              w_opb   = w_mb;
              w_neg   = w_sa ^ w_sb;
              w_rneg  = w_sa;
              w_hi    = bus.op[1];
            end
`endif
            default: begin
              w_state   = DONE;
              w_result  = w_alu;
              w_illegal = w_ill;
            end
          endcase
        end
      end
      MUL: begin
        w_acc = w_mstep;
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state  = DONE;
          w_result = r_hi ? w_prod[2*WIDTH-1:WIDTH]
                          : w_prod[WIDTH-1:0];
        end
      end
`ifdef MDL_DIV_EN
      DIV: begin
        w_acc = w_dstep;
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state  = DONE;
          w_result = r_hi ? w_rem : w_quo;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_result  <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_neg     <= 1'b0;
      r_hi      <= 1'b0;
`ifdef MDL_DIV_EN
      r_rneg    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_result  <= w_result;
      r_illegal <= w_illegal;
      r_cnt     <= w_cnt;
      r_acc     <= w_acc;
      r_opb     <= w_opb;
      r_neg     <= w_neg;
      r_hi      <= w_hi;
`ifdef MDL_DIV_EN
      r_rneg    <= w_rneg;
`endif
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_mdl_unit.sv
// tb_mdl_unit: directed bench for mdl_unit at WIDTH=32 with an
// arithmetic reference model and a per-cycle output compare.
module tb_mdl_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdl_unit_if #(.WIDTH(32)) bus ();
  mdl_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: result, illegal flag and latency from plain arithmetic.
  function automatic void model(input logic [4:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] r,
                                output logic ill,
                                output int lat);
    logic signed [63:0] sa, sb, ua, ub, p, x, y, q, m;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    r   = a + b;
    ill = 1'b0;
    lat = 1;
    case (op)
      5'd0: r = a & b;
      5'd1: r = a | b;
      5'd2: r = a + b;
      5'd3: r = a - b;
      5'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd5: r = a >> b[4:0];
      5'd6: r = a << b[4:0];
      5'd7: r = $signed(a) >>> b[4:0];
      5'd8: r = a ^ b;
      5'd9: r = (a < b) ? 32'd1 : 32'd0;
      5'd16: begin p = sa * sb; r = p[31:0];  lat = 33; end
      5'd17: begin p = sa * sb; r = p[63:32]; lat = 33; end
      5'd18: begin p = sa * ub; r = p[63:32]; lat = 33; end
      5'd19: begin p = ua * ub; r = p[63:32]; lat = 33; end
`ifdef MDL_DIV_EN
      5'd20, 5'd21, 5'd22, 5'd23: begin
        x = op[0] ? ua : sa;
        y = op[0] ? ub : sb;
        if (b == 32'd0) begin
          r = op[1] ? a : 32'hFFFF_FFFF;
        end else begin
          q = x / y;
          m = x % y;
          r = op[1] ? m[31:0] : q[31:0];
          lat = (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                ? 1 : 33;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Transaction-level expectation tracker.
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_ill   = 1'b0;
  logic        p_ill   = 1'b0;
  logic [31:0] m_res   = '0;
  logic [31:0] p_res   = '0;
  int          m_left  = 0;

  always @(posedge clk) begin
    logic [31:0] r;
    logic        il;
    int          lt;
    if (rst) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (bus.out_ready) m_valid = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
        m_res   = p_res;
        m_ill   = p_ill;
      end
    end else if (bus.in_valid) begin
      model(bus.op, bus.input1, bus.input2, r, il, lt);
      if (lt == 1) begin
        m_valid = 1'b1;
        m_res   = r;
        m_ill   = il;
      end else begin
        m_busy = 1'b1;
        m_left = lt - 1;
        p_res  = r;
        p_ill  = il;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready", 64'(bus.in_ready),
          64'(!rst && !m_busy && !m_valid));
    check("cyc_out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      check("cyc_result", 64'(bus.result), 64'(m_res));
      check("cyc_illegal", 64'(bus.illegal), 64'(m_ill));
    end
  end

  task automatic run(input string nm, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ei,
                     input int el);
    logic [31:0] mr;
    logic        mi;
    int          ml;
    int          n;
    model(op, a, b, mr, mi, ml);
    check({nm, "_model_res"}, 64'(mr), 64'(er));
    check({nm, "_model_lat"}, 64'(ml), 64'(el));
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.input1   = a;
    bus.input2   = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.input1   = $urandom;
    bus.input2   = $urandom;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_lat"}, 64'(n), 64'(el));
    check({nm, "_res"}, 64'(bus.result), 64'(er));
    check({nm, "_ill"}, 64'(bus.illegal), 64'(ei));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bus.in_valid  = 1'b0;
    bus.op        = 5'd0;
    bus.input1    = '0;
    bus.input2    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);

    run("sra",   5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
    run("ltu",   5'd9, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
    run("lt",    5'd4, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    run("and",   5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
    run("or",    5'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1);
    run("add",   5'd2, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1);
    run("sub",   5'd3, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    run("srl",   5'd5, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
    run("sll",   5'd6, 32'd1, 32'h0000_003F, 32'h8000_0000, 1'b0, 1);
    run("xor",   5'd8, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1);
    run("mul",   5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
    run("mulh",  5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    run("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
    run("mul_neg", 5'd16, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_F448, 1'b0, 33);
`ifdef MDL_DIV_EN
    run("div",   5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    run("rem",   5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run("divu0", 5'd21, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run("remu0", 5'd23, 32'd7, 32'd0, 32'd7, 1'b0, 1);
    run("divov", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run("remov", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    run("divu",  5'd21, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    run("remu",  5'd23, 32'd100, 32'd7, 32'd2, 1'b0, 33);
`else
    run("op20",  5'd20, 32'd7, 32'd5, 32'd12, 1'b1, 1);
`endif
    run("op31",  5'd31, 32'd3, 32'd4, 32'd7, 1'b1, 1);
    run("after_ill", 5'd2, 32'd1, 32'd1, 32'd2, 1'b0, 1);

    // Backpressure: result held, new requests dropped.
    bus.in_valid = 1'b1;
    bus.op       = 5'd2;
    bus.input1   = 32'd10;
    bus.input2   = 32'd20;
    @(negedge clk);
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    check("bp_first", 64'(bus.result), 64'd30);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.op       = 5'd3;
      bus.input1   = $urandom;
      bus.input2   = $urandom;
      @(negedge clk);
      check("bp_hold_res", 64'(bus.result), 64'd30);
      check("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
      check("bp_hold_vld", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_rel_vld", 64'(bus.out_valid), 64'd0);
    check("bp_rel_rdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("bp_dropped", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a multiply.
    bus.in_valid = 1'b1;
    bus.op       = 5'd16;
    bus.input1   = 32'd3;
    bus.input2   = 32'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_rdy_in_rst", 64'(bus.in_ready), 64'd0);
    check("mrst_vld_in_rst", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready", 64'(bus.in_ready), 64'd1);
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_result", 64'(bus.result), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check("mrst_no_result", 64'(seen), 64'd0);

    run("final_mul", 5'd16, 32'd3, 32'd5, 32'd15, 1'b0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdl_unit.md
# mdl_unit

Parametrised execute unit that succeeds the single-cycle logic/arithmetic unit in the processor's execute stage. It is WIDTH bits wide and registered, with a valid/ready handshake on both sides. It adds unsigned compare, iterative multiply (RV32M MUL/MULH/MULHSU/MULHU) and iterative divide/remainder (DIV/DIVU/REM/REMU). The stage controller stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32, operand/result width; must be ≥ 8 and a power of two; `SHAMT_W = $clog2(WIDTH)` is derived locally.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  operation request
- `in_ready`  out  1  unit can accept; `(state==IDLE) && !rst`
- `op`  in  5  operation code (encodings below)
- `input1`  in  WIDTH  operand A / dividend / multiplicand
- `input2`  in  WIDTH  operand B / divisor / multiplier; shifts use `[SHAMT_W-1:0]`
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `result`  out  WIDTH  registered result
- `illegal`  out  1  registered; op code unsupported

## Operation
- Op codes:
  - AND=0, OR=1, ADD=2, SUB=3, LT(signed)=4, SRL=5, SLL=6, SRA=7, XOR=8, LTU=9.
  - MUL=16, MULH=17, MULHSU=18, MULHU=19.
  - DIV=20, DIVU=21, REM=22, REMU=23.
  - All other codes: `illegal`=1, `result`=`input1+input2`, 1-cycle path.
- Compare results are zero-extended, 0 or 1.
- Transfer rules: accept on `in_valid && in_ready`; result consumed on `out_valid && out_ready`.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → DONE: on accept of a basic/illegal op; result computed and registered on the accept edge.
  - IDLE → MUL: on accept of a multiply op. Operands are latched, sign-corrected per op (MULHSU: A signed, B unsigned), and magnitudes are taken.
  - MUL: radix-2 shift-add over a 2·WIDTH product, one bit per cycle for WIDTH cycles. Final cycle negates the product if signs differ, selects the low half (MUL) or high half, then → DONE.
  - IDLE → DIV: on accept of a divide/remainder op, unless a special case applies.
  - DIV: restoring division on magnitudes for WIDTH cycles. Final cycle applies signs (quotient negative if operand signs differ; remainder takes the dividend's sign), then → DONE.
  - DONE: `out_valid`=1. On `out_ready` → IDLE. No new request is accepted in DONE.
- Divide special cases, taking IDLE → DONE directly with 1-cycle latency:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = `-2^(WIDTH-1)`, divisor = −1): quotient = dividend; remainder = 0.
- Iteration counter: SHAMT_W+1 bits, cleared on entry to MUL/DIV.

## Timing
- Reset values: state IDLE, `out_valid` 0, `result` 0, `illegal` 0, counter 0. `in_ready` is 0 during the reset cycle and 1 on the following cycle.
- Latency, measured from accept edge to the first cycle with `out_valid`=1:
  - Basic/illegal ops and divide special cases: 1 cycle.
  - MUL and DIV iterative ops: WIDTH+1 cycles (33 at WIDTH=32).
- While `out_valid && !out_ready`, `result` and `illegal` are held stable and `in_ready` stays 0.
- Back-to-back: after the consuming edge the unit is in IDLE. The next accept is at the earliest one cycle after consumption, so throughput is at most 1 op per 2 cycles.
- `in_valid` asserted while `in_ready`=0 is ignored; no request is queued.
- `rst` mid-operation: on the next edge the unit is in IDLE. The in-flight operation is discarded and no `out_valid` is produced for it.
- Operand inputs are don't-care except on the accept cycle.

## Configuration
- Macro: `MDL_DIV_EN`.
- Defined: DIV/DIVU/REM/REMU are implemented as specified, including the DIV state and divider datapath.
- Undefined:
  - The DIV state and divider datapath are not built.
  - Op codes 20–23 are treated as illegal: `illegal`=1, `result`=`input1+input2`, 1-cycle latency.
- Multiply is always built.

## Test plan
- SRA `input1`=0x80000000, `input2`=4 → `result` 0xF8000000, `illegal`=0, `out_valid` one cycle after accept. LTU with 0x1 and 0xFFFFFFFF → 1; LT with the same operands → 0.
- `input1`=`input2`=0xFFFFFFFF:
  - MUL → 0x00000001; MULH → 0x00000000; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
  - Each with `out_valid` exactly 33 cycles after accept.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF, each at 33 cycles. DIVU 7/0 → 0xFFFFFFFF and REMU 7/0 → 7, at 1 cycle. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, at 1 cycle.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` while pulsing `in_valid` with a new op. `result` stays unchanged, `in_ready`=0 and the new op is dropped. Releasing `out_ready` returns the unit to IDLE the next cycle.
- Assert `rst` 10 cycles into a MUL. Next cycle: `in_ready`=1, `out_valid`=0, `result`=0, and no result for the MUL ever appears.
- `op`=31 → `illegal`=1, `result`=`input1+input2`. With `MDL_DIV_EN` undefined, `op`=20 gives the same response.
